// File: rtl/booth_mul64.sv
// Iterative radix-4 Booth multiplier returning the low XLEN bits of A*B (RV64 MUL).
// Optional MUL_EARLY_EXIT_EN: finish as soon as no nonzero Booth digits remain.
module booth_mul64 #(
   parameter int unsigned XLEN = 64
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_mul_valid,
   input  logic            i_flush,
   input  logic [XLEN-1:0] i_multiplicand,
   input  logic [XLEN-1:0] i_multiplier,
   output logic            o_mul_ready,
   output logic            o_out_valid,
   output logic [XLEN-1:0] o_result
);

   localparam int unsigned ITERS = XLEN / 2;
   localparam int unsigned CNT_W = $clog2(ITERS) + 1;
   localparam int unsigned QW    = XLEN + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [XLEN-1:0]   r_m;
   logic [QW-1:0]     r_q;
   logic [XLEN-1:0]   r_acc;
   logic [CNT_W-1:0]  r_count;

   logic [XLEN-1:0]   w_m2;
   logic [XLEN-1:0]   w_partial;
   logic [XLEN-1:0]   w_acc_next;
   logic [QW-1:0]     w_q_next;
   logic [CNT_W-1:0]  w_count_next;
   logic              w_accept;
   logic              w_step;
   logic              w_last;

   assign o_mul_ready = (r_state == S_IDLE);

   // Booth digit selection from the current 3-bit window (bit 0 is the look-back bit)
   assign w_m2 = {r_m[XLEN-2:0], 1'b0};
   always_comb begin
      w_partial = '0;
      case (r_q[2:0])
         3'b001, 3'b010: w_partial = r_m;
         3'b011:         w_partial = w_m2;
         3'b100:         w_partial = XLEN'(0) - w_m2;
         3'b101, 3'b110: w_partial = XLEN'(0) - r_m;
         default:        w_partial = '0;
      endcase
   end

   assign w_acc_next   = r_acc + w_partial;
   assign w_q_next     = {{2{r_q[QW-1]}}, r_q[QW-1:2]};
   assign w_count_next = r_count + CNT_W'(1);

`ifdef MUL_EARLY_EXIT_EN
   assign w_last = (w_count_next == CNT_W'(ITERS)) || (w_q_next == '0);
`else
   assign w_last = (w_count_next == CNT_W'(ITERS));
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state: flush aborts anything in flight and blocks a same-cycle accept
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_step       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_mul_valid && !i_flush) begin
               w_accept     = 1'b1;
               w_state_next = S_BUSY;
            end
         end
         S_BUSY: begin
            if (i_flush) begin
               w_state_next = S_IDLE;
            end else begin
               w_step = 1'b1;
               if (w_last) w_state_next = S_DONE;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_m         <= '0;
         r_q         <= '0;
         r_acc       <= '0;
         r_count     <= '0;
         o_result    <= '0;
         o_out_valid <= 1'b0;
      end else begin
         o_out_valid <= w_step && w_last;
         if (w_accept) begin
            r_m     <= i_multiplicand;
            r_q     <= {i_multiplier, 1'b0};
            r_acc   <= '0;
            r_count <= '0;
         end else if (w_step) begin
            r_acc   <= w_acc_next;
            r_m     <= {r_m[XLEN-3:0], 2'b00};
            r_q     <= w_q_next;
            r_count <= w_count_next;
            if (w_last) o_result <= w_acc_next;
         end
      end
   end

endmodule

// File: tb/tb_booth_mul64.sv
// Self-checking bench for booth_mul64: directed vector table, random vectors
// against a plain-arithmetic reference, and flush/reset/ignore sequences.
module tb_booth_mul64;

   logic        clk = 1'b0;
   logic        rst;
   logic        mul_valid;
   logic        flush;
   logic [63:0] a_in;
   logic [63:0] b_in;
   logic        ready;
   logic        ov;
   logic [63:0] res;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[$];

   booth_mul64 #(.XLEN(64)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_mul_valid    (mul_valid),
      .i_flush        (flush),
      .i_multiplicand (a_in),
      .i_multiplier   (b_in),
      .o_mul_ready    (ready),
      .o_out_valid    (ov),
      .o_result       (res)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y);
      return x * y;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, got, exp);
      end
   endtask

   task automatic wait_done(output bit seen, output int cyc);
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         seen = ov;
      end
   endtask

   task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input string tag);
      bit seen;
      int cyc;
      @(negedge clk);
      a_in = a; b_in = b; mul_valid = 1'b1;
      @(negedge clk);
      mul_valid = 1'b0;
      chk({tag, "_ready_drop"}, 64'(ready), 64'd0);
      wait_done(seen, cyc);
      chk({tag, "_done_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         chk({tag, "_result"}, res, exp);
         chk({tag, "_ready_in_done"}, 64'(ready), 64'd0);
`ifdef MUL_EARLY_EXIT_EN
         chk({tag, "_latency_max"}, 64'(cyc <= 32), 64'd1);
         if (b == 64'd0) chk({tag, "_latency_zero"}, 64'(cyc), 64'd1);
`else
         chk({tag, "_latency"}, 64'(cyc), 64'd32);
`endif
         @(negedge clk);
         chk({tag, "_pulse_end"}, 64'(ov), 64'd0);
         chk({tag, "_ready_back"}, 64'(ready), 64'd1);
         chk({tag, "_hold"}, res, exp);
      end
   endtask

   initial begin
      bit seen;
      int cyc;
      int pulses;
      logic [63:0] ra, rb;

      rst = 1'b1; mul_valid = 1'b0; flush = 1'b0; a_in = '0; b_in = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_ready", 64'(ready), 64'd1);
      chk("reset_out_valid", 64'(ov), 64'd0);
      chk("reset_result", res, 64'd0);

      vecs.push_back('{64'd3, 64'd5, 64'h000000000000000F});
      vecs.push_back('{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001});
      vecs.push_back('{64'h00000000FFFFFFFF, 64'h00000000FFFFFFFF, 64'hFFFFFFFE00000001});
      vecs.push_back('{64'h8000000000000000, 64'd2, 64'd0});
      vecs.push_back('{64'hFFFFFFFFFFFFFFFE, 64'd7, 64'hFFFFFFFFFFFFFFF2});
      vecs.push_back('{64'd0, 64'd123, 64'd0});
      vecs.push_back('{64'd123, 64'd0, 64'd0});
      vecs.push_back('{64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, 64'h0000000000000001});
      vecs.push_back('{64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000});
      vecs.push_back('{64'h0000000100000000, 64'h0000000100000000, 64'd0});

      for (int i = 0; i < vecs.size(); i++)
         do_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

      for (int i = 0; i < 24; i++) begin
         ra = {$urandom, $urandom};
         rb = (i % 4 == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
         do_op(ra, rb, ref_mul(ra, rb), $sformatf("rand%0d", i));
      end

      // Flush mid-operation: no pulse, result untouched, idle right after.
      do_op(64'd9, 64'd9, 64'd81, "pre_flush");
      @(negedge clk);
      a_in = 64'd7; b_in = 64'h4000000000000006; mul_valid = 1'b1;
      @(negedge clk);
      mul_valid = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_ready", 64'(ready), 64'd1);
      chk("flush_out_valid", 64'(ov), 64'd0);
      chk("flush_result_kept", res, 64'd81);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (ov) pulses++;
      end
      chk("flush_no_pulse", 64'(pulses), 64'd0);

      // 7*6 with an ignored 1*1 request while busy.
      @(negedge clk);
      a_in = 64'd7; b_in = 64'd6; mul_valid = 1'b1;
      @(negedge clk);
      a_in = 64'd1; b_in = 64'd1;
      @(negedge clk);
      mul_valid = 1'b0;
      wait_done(seen, cyc);
      chk("ignore_done_seen", 64'(seen), 64'd1);
      chk("ignore_result", res, 64'h2A);
`ifndef MUL_EARLY_EXIT_EN
      chk("ignore_latency", 64'(cyc + 1), 64'd32);
`endif
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (ov) pulses++;
      end
      chk("ignore_no_second", 64'(pulses), 64'd0);
      chk("ignore_ready", 64'(ready), 64'd1);
      chk("ignore_hold", res, 64'h2A);

      // Reset mid-operation.
      @(negedge clk);
      a_in = 64'd5; b_in = 64'h4000000000000003; mul_valid = 1'b1;
      @(negedge clk);
      mul_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_out_valid", 64'(ov), 64'd0);
      chk("rst_mid_result", res, 64'd0);
      chk("rst_mid_ready", 64'(ready), 64'd1);

      // mul_valid together with flush in IDLE must not be accepted.
      a_in = 64'd11; b_in = 64'd13; mul_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      mul_valid = 1'b0; flush = 1'b0;
      chk("valid_flush_ready", 64'(ready), 64'd1);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (ov) pulses++;
      end
      chk("valid_flush_no_pulse", 64'(pulses), 64'd0);
      chk("valid_flush_result", res, 64'd0);

      do_op(64'd11, 64'd13, 64'd143, "post_seq");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
